// File: rtl/audio_pkg.sv
// Shared audio front-end definitions: sample/frame geometry and framing FSM states.
// Defining FRAME_OVERLAP_EN adds the HOP state used for 50%-overlapped frames.
package audio_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_LEN = 20;

  function automatic int unsigned hop_len_of(input int unsigned frame_len);
    return frame_len / 2;
  endfunction

  localparam int unsigned HOP_LEN = hop_len_of(FRAME_LEN);

`ifdef FRAME_OVERLAP_EN
  typedef enum logic [1:0] {StIdle, StFill, StHop} frame_state_e;
`else
  typedef enum logic [0:0] {StIdle, StFill} frame_state_e;
`endif

endpackage

// File: rtl/frame_collector.sv
// Collects accepted audio samples into FRAME_LEN-sample frames, oldest sample at index 0.
// Define FRAME_OVERLAP_EN to emit every FRAME_LEN/2 samples after the first frame.
module frame_collector
  import audio_pkg::frame_state_e;
#(
  parameter int unsigned DATA_W    = audio_pkg::DATA_W,
  parameter int unsigned FRAME_LEN = audio_pkg::FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] frame_out [0:FRAME_LEN-1],
  output logic              frame_valid,
  output logic [7:0]        frame_idx
);

  localparam int unsigned     CntW     = $clog2(FRAME_LEN + 1);
  localparam logic [CntW-1:0] LastFill = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  frame_state_e      state_q;
  logic [CntW-1:0]   fill_cnt_q;
  logic [DATA_W-1:0] hist_q [0:FRAME_LEN-1];
  logic              emit;

`ifdef FRAME_OVERLAP_EN
  localparam int unsigned     HopLen  = audio_pkg::hop_len_of(FRAME_LEN);
  localparam int unsigned     HopW    = $clog2(HopLen + 1);
  localparam logic [HopW-1:0] LastHop = HopW'(HopLen - 1);
  localparam logic [HopW-1:0] HopOne  = HopW'(1);
  logic [HopW-1:0] hop_cnt_q;
`endif

  // A restart takes priority: a sample arriving with frame_start begins a new frame.
  always_comb begin
    emit = 1'b0;
    if (sample_valid && !frame_start) begin
      unique case (state_q)
        audio_pkg::StFill: emit = (fill_cnt_q == LastFill);
`ifdef FRAME_OVERLAP_EN
        audio_pkg::StHop:  emit = (hop_cnt_q == LastHop);
`endif
        default:           emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= audio_pkg::StIdle;
      fill_cnt_q  <= '0;
`ifdef FRAME_OVERLAP_EN
      hop_cnt_q   <= '0;
`endif
      frame_valid <= 1'b0;
      frame_idx   <= '0;
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
        hist_q[i]    <= '0;
        frame_out[i] <= '0;
      end
    end else begin
      frame_valid <= emit;
      if (frame_start) begin
        for (int unsigned i = 0; i < FRAME_LEN - 1; i++) hist_q[i] <= '0;
        hist_q[FRAME_LEN-1] <= sample_valid ? sample_in : '0;
        state_q    <= sample_valid ? audio_pkg::StFill : audio_pkg::StIdle;
        fill_cnt_q <= sample_valid ? CntOne : '0;
`ifdef FRAME_OVERLAP_EN
        hop_cnt_q  <= '0;
`endif
      end else if (sample_valid) begin
        for (int unsigned i = 0; i < FRAME_LEN - 1; i++) hist_q[i] <= hist_q[i+1];
        hist_q[FRAME_LEN-1] <= sample_in;
        if (emit) begin
          // Frame includes the sample being accepted on this edge.
          for (int unsigned i = 0; i < FRAME_LEN - 1; i++) frame_out[i] <= hist_q[i+1];
          frame_out[FRAME_LEN-1] <= sample_in;
          frame_idx <= frame_idx + 8'd1;
        end
        unique case (state_q)
          audio_pkg::StIdle: begin
            state_q    <= audio_pkg::StFill;
            fill_cnt_q <= CntOne;
          end
          audio_pkg::StFill: begin
            if (emit) begin
              fill_cnt_q <= '0;
`ifdef FRAME_OVERLAP_EN
              state_q    <= audio_pkg::StHop;
              hop_cnt_q  <= '0;
`else
              state_q    <= audio_pkg::StFill;
`endif
            end else begin
              fill_cnt_q <= fill_cnt_q + CntOne;
            end
          end
`ifdef FRAME_OVERLAP_EN
          audio_pkg::StHop: hop_cnt_q <= emit ? '0 : hop_cnt_q + HopOne;
`endif
          default: state_q <= audio_pkg::StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_collector.sv
// Self-checking bench for frame_collector: queue-based framing model plus directed scenarios.
// Honours FRAME_OVERLAP_EN for the overlapped-frame expectations.
module tb_frame_collector;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 20;
  localparam int HOP       = FRAME_LEN / 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic              frame_start = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [DATA_W-1:0] frame_out [0:FRAME_LEN-1];
  logic              frame_valid;
  logic [7:0]        frame_idx;

  frame_collector #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_start  (frame_start),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .frame_idx    (frame_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples since the last restart, newest at the back.
  logic [DATA_W-1:0] m_hist [$];
  int                m_n = 0;
  logic [DATA_W-1:0] m_frame [0:FRAME_LEN-1];
  bit                m_valid = 1'b0;
  int                m_idx = 0;

  int                strobes = 0;
  logic [DATA_W-1:0] q_first [$];
  logic [DATA_W-1:0] q_last [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit emit_at(input int n);
`ifdef FRAME_OVERLAP_EN
    return (n >= FRAME_LEN) && (((n - FRAME_LEN) % HOP) == 0);
`else
    return (n % FRAME_LEN) == 0;
`endif
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_n = 0;
    m_valid = 1'b0;
    m_idx = 0;
    for (int i = 0; i < FRAME_LEN; i++) m_frame[i] = '0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_valid = 1'b0;
      if (frame_start) begin
        m_hist.delete();
        m_n = 0;
      end
      if (sample_valid) begin
        m_hist.push_back(sample_in);
        if (m_hist.size() > FRAME_LEN) void'(m_hist.pop_front());
        m_n++;
        if (emit_at(m_n)) begin
          for (int i = 0; i < FRAME_LEN; i++) m_frame[i] = m_hist[i];
          m_valid = 1'b1;
          m_idx = (m_idx + 1) % 256;
        end
      end
    end
  endtask

  task automatic compare_frame();
    int bad = -1;
    for (int i = 0; i < FRAME_LEN; i++)
      if (bad < 0 && frame_out[i] !== m_frame[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL frame_out[%0d]: got %0d expected %0d", bad, frame_out[bad], m_frame[bad]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("frame_valid", 32'(frame_valid), 32'(m_valid));
      check("frame_idx", 32'(frame_idx), m_idx);
      compare_frame();
    end
  end

  task automatic send(input logic v, input logic [DATA_W-1:0] s, input logic fs);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    frame_start  = fs;
    @(posedge clk);
    #2;
    if (frame_valid === 1'b1) begin
      strobes++;
      q_first.push_back(frame_out[0]);
      q_last.push_back(frame_out[FRAME_LEN-1]);
    end
  endtask

  // Asserts rst between clock edges and checks the asynchronous clear at once.
  task automatic do_reset();
    int nz = 0;
    @(negedge clk);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < FRAME_LEN; i++) if (frame_out[i] !== '0) nz++;
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_idx", 32'(frame_idx), 32'd0);
    check("rst_frame_out_nonzero", nz, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    q_first.delete();
    q_last.delete();
  endtask

  int pre;
  int n;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Samples 1..20 continuous.
    do_reset();
    for (int i = 1; i <= FRAME_LEN; i++) begin
      send(1'b1, DATA_W'(i), 1'b0);
      if (i == FRAME_LEN - 1) check("t1_no_early_strobe", 32'(frame_valid), 32'd0);
    end
    check("t1_valid", 32'(frame_valid), 32'd1);
    check("t1_first", 32'(frame_out[0]), 32'd1);
    check("t1_last", 32'(frame_out[FRAME_LEN-1]), 32'd20);
    check("t1_idx", 32'(frame_idx), 32'd1);
    send(1'b0, '0, 1'b0);
    check("t1_one_cycle", 32'(frame_valid), 32'd0);

    // 40 samples with sample_valid toggling.
    do_reset();
    for (int i = 1; i <= 2 * FRAME_LEN; i++) begin
      send(1'b1, DATA_W'(i), 1'b0);
      send(1'b0, '0, 1'b0);
    end
`ifdef FRAME_OVERLAP_EN
    check("t2_strobes", strobes, 32'd3);
    if (q_first.size() >= 3) begin
      check("t2_f2_first", 32'(q_first[1]), 32'd11);
      check("t2_f2_last", 32'(q_last[1]), 32'd30);
      check("t2_f3_first", 32'(q_first[2]), 32'd21);
      check("t2_f3_last", 32'(q_last[2]), 32'd40);
    end
`else
    check("t2_strobes", strobes, 32'd2);
    if (q_first.size() >= 2) begin
      check("t2_f2_first", 32'(q_first[1]), 32'd21);
      check("t2_f2_last", 32'(q_last[1]), 32'd40);
    end
`endif

    // Restart mid-frame with a sample on the same edge.
`ifdef FRAME_OVERLAP_EN
    pre = 5;
`else
    pre = 12;
`endif
    do_reset();
    for (int i = 1; i <= FRAME_LEN; i++) send(1'b1, DATA_W'(i), 1'b0);
    for (int i = 1; i <= pre; i++) send(1'b1, DATA_W'(200 + i), 1'b0);
    send(1'b1, DATA_W'(100), 1'b1);
    for (int i = 1; i <= FRAME_LEN - 1; i++) begin
      send(1'b1, DATA_W'(100 + i), 1'b0);
      if (i == FRAME_LEN - 2) check("t3_old_frame_held", 32'(frame_out[0]), 32'd1);
    end
    check("t3_valid", 32'(frame_valid), 32'd1);
    check("t3_first", 32'(frame_out[0]), 32'd100);
    check("t3_last", 32'(frame_out[FRAME_LEN-1]), 32'd119);
    check("t3_idx", 32'(frame_idx), 32'd2);

    // Reset after 15 samples of a partial frame.
    do_reset();
    for (int i = 1; i <= FRAME_LEN + 15; i++) send(1'b1, DATA_W'(i), 1'b0);
    do_reset();
    for (int i = 1; i < FRAME_LEN; i++) send(1'b1, DATA_W'(500 + i), 1'b0);
    check("t4_no_strobe", strobes, 32'd0);
    send(1'b1, DATA_W'(520), 1'b0);
    check("t4_valid", 32'(frame_valid), 32'd1);
    check("t4_first", 32'(frame_out[0]), 32'd501);
    check("t4_idx", 32'(frame_idx), 32'd1);

    // Random stream with sporadic restarts.
    do_reset();
    for (int i = 0; i < 3000; i++)
      send(1'(($urandom % 10) < 7), DATA_W'($urandom), 1'(($urandom % 50) == 0));

    // frame_idx wrap.
    do_reset();
    n = 0;
    while (strobes < 257 && n < 6000) begin
      send(1'b1, DATA_W'(n), 1'b0);
      n++;
      if (frame_valid === 1'b1 && strobes == 256) check("t6_idx_256", 32'(frame_idx), 32'd0);
      if (frame_valid === 1'b1 && strobes == 257) check("t6_idx_257", 32'(frame_idx), 32'd1);
    end
    check("t6_strobes", strobes, 32'd257);

    send(1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
